fill_rect: RTL and testbench
============================

FILL_RECT -- requirements
Module: fill_rect

Interface
REQ-001 The block SHALL have parameter H_RES, default 160, the screen width in pixels.
REQ-002 The block SHALL have parameter V_RES, default 120, the screen height in pixels.
REQ-003 The block SHALL have parameter X_W, default 8, the x coordinate width; Y_W, default 7, the y coordinate width.
REQ-004 The block SHALL have parameter COLOUR_W, default 3, the colour width.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-007 The block SHALL have port start, input, 1, the level request to begin a fill.
REQ-008 The block SHALL have port mode, input, 2, the colour pattern select.
REQ-009 The block SHALL have ports colour_in (COLOUR_W), x0/x1 (X_W) and y0/y1 (Y_W), all inputs: fill colour and inclusive rectangle corners.
REQ-010 The block SHALL have port plot_ready, input, 1, the downstream accept; a pixel transfers when vga_plot and plot_ready are both 1.
REQ-011 The block SHALL have port done, output, 1, the fill-complete flag.
REQ-012 The block SHALL have ports vga_x (X_W), vga_y (Y_W), vga_colour (COLOUR_W) and vga_plot (1), all outputs: the pixel write to the VGA adapter.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, FILL and DONE.
REQ-014 IDLE: when start=1, the block SHALL latch mode, colour_in, x0, x1, y0 and y1, then go to SETUP on the next edge.
REQ-015 SETUP, one cycle: the block SHALL clip x1 to min(x1, H_RES-1) and y1 to min(y1, V_RES-1).
REQ-016 SETUP: if x0>clipped x1 or y0>clipped y1, the block SHALL go to DONE with zero pixels plotted; otherwise it SHALL set x=x0, y=y0 and go to FILL.
REQ-017 FILL SHALL use column-major order: y increments inside each column; when y reaches y1, y returns to y0 and x increments.
REQ-018 FILL: vga_plot SHALL be 1 every cycle; vga_x, vga_y and vga_colour SHALL remain stable while plot_ready=0.
REQ-019 FILL: the block SHALL advance one pixel per cycle in which plot_ready=1.
REQ-020 FILL: the transfer of pixel (x1,y1) SHALL move the FSM to DONE on the same edge; exactly (x1-x0+1)*(y1-y0+1) transfers occur.
REQ-021 Colour for pattern 0 SHALL be colour_in (solid).
REQ-022 Colour for pattern 1 SHALL be x[COLOUR_W-1:0] (column stripes).
REQ-023 Colour for pattern 2 SHALL be y[COLOUR_W-1:0] (row stripes).
REQ-024 Colour for pattern 3 SHALL be (x^y)[COLOUR_W-1:0], with y zero-extended to COLOUR_W when Y_W<COLOUR_W.
REQ-025 DONE: done=1 and vga_plot=0; when start=0 the FSM SHALL return to IDLE on the next edge.
REQ-026 DONE: while start stays 1, the FSM SHALL hold in DONE; there is no re-trigger without a start low phase.
REQ-027 done SHALL be 0 in every state except DONE.
REQ-028 Inputs other than start and plot_ready SHALL be ignored outside IDLE; changes during a fill SHALL not alter that fill.
REQ-029 Counters SHALL be sized so that x=H_RES-1 and y=V_RES-1 produce no wrap or overflow.
REQ-030 A 1x1 rectangle (x0=x1, y0=y1) SHALL produce exactly one transfer.
REQ-031 The block SHALL reach IDLE->done with latency 2 + transfer count + stall cycles.

Reset
REQ-032 While rst=1 at a clock edge, the FSM SHALL go to IDLE regardless of state, including mid-FILL.
REQ-033 After reset, the block SHALL drive done=0, vga_plot=0, vga_x=0, vga_y=0 and vga_colour=0, with all latched registers at 0.
REQ-034 After reset, no further pixel of an aborted fill SHALL be plotted.
REQ-035 If start=1 on the first edge with rst=0, a new fill SHALL begin; start high during reset is not remembered.

Verification
REQ-036 Full screen: mode=1, x0=0, y0=0, x1=255, y1=255, plot_ready=1 -> 19200 transfers; first (0,0) colour 0, last (159,119) colour 7; done rises 19202 cycles after start.
REQ-037 Clipped solid: mode=0, colour_in=5, x0=150, y0=110, x1=200, y1=127 -> 10x10=100 transfers, all colour 5, order (150,110),(150,111)..(159,119).
REQ-038 Empty/degenerate: x0=10, x1=9 -> done 2 cycles after start with no vga_plot.
REQ-039 Empty/degenerate: x0=x1=3, y0=y1=4, mode=3 -> one transfer at (3,4) colour 7.
REQ-040 Backpressure: mode=2 on 2x2 from (0,0), plot_ready toggling 1,0,1,0... -> outputs hold during 0 cycles; exactly 4 transfers, colours 0,1,0,1.
REQ-041 Reset mid-fill: rst=1 after 50 transfers -> next cycle vga_plot=0, done=0; a new start then runs a full fill correctly.
REQ-042 Handshake: start held high after done -> done stays 1 with no new plots; start=0 -> IDLE; start=1 again -> a second fill occurs.

Source files
------------

// File: rtl/fill_rect.sv
// Rectangle filler: walks an inclusive, screen-clipped rectangle in column-major
// order and emits one pixel write per accepted handshake.
module fill_rect #(
    parameter int unsigned H_RES    = 160,
    parameter int unsigned V_RES    = 120,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic [X_W-1:0]      x0,
    input  logic [X_W-1:0]      x1,
    input  logic [Y_W-1:0]      y0,
    input  logic [Y_W-1:0]      y1,
    input  logic                plot_ready,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int unsigned XY_W  = (X_W > Y_W) ? X_W : Y_W;
    localparam int unsigned EXT_W = (XY_W > COLOUR_W) ? XY_W : COLOUR_W;

    localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [1:0]            r_mode;
    logic [COLOUR_W-1:0]   r_colour_in;
    logic [X_W-1:0]        r_x0;
    logic [X_W-1:0]        r_x1;
    logic [Y_W-1:0]        r_y0;
    logic [Y_W-1:0]        r_y1;

    logic [X_W-1:0]        r_x;
    logic [Y_W-1:0]        r_y;
    logic [COLOUR_W-1:0]   r_vga_colour;
    logic                  r_plot;
    logic                  r_done;

    logic [X_W-1:0]        w_x1_clip;
    logic [Y_W-1:0]        w_y1_clip;
    logic                  w_empty;
    logic [X_W-1:0]        w_x_nxt;
    logic [Y_W-1:0]        w_y_nxt;
    logic [COLOUR_W-1:0]   w_colour_nxt;

    // Pattern colour for a pixel; both coordinates are zero-extended before mixing.
    function automatic logic [COLOUR_W-1:0] pattern_colour(
        input logic [1:0]          m,
        input logic [COLOUR_W-1:0] c,
        input logic [X_W-1:0]      px,
        input logic [Y_W-1:0]      py
    );
        logic [EXT_W-1:0] xe;
        logic [EXT_W-1:0] ye;
        xe = EXT_W'(px);
        ye = EXT_W'(py);
        case (m)
            2'd0:    pattern_colour = c;
            2'd1:    pattern_colour = COLOUR_W'(xe);
            2'd2:    pattern_colour = COLOUR_W'(ye);
            default: pattern_colour = COLOUR_W'(xe ^ ye);
        endcase
    endfunction

    assign w_x1_clip    = (r_x1 > X_MAX) ? X_MAX : r_x1;
    assign w_y1_clip    = (r_y1 > Y_MAX) ? Y_MAX : r_y1;
    assign w_empty      = (r_x0 > w_x1_clip) || (r_y0 > w_y1_clip);
    assign w_colour_nxt = pattern_colour(r_mode, r_colour_in, w_x_nxt, w_y_nxt);

    // Next state and next scan position
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_empty) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_FILL;
                    w_x_nxt     = r_x0;
                    w_y_nxt     = r_y0;
                end
            end
            ST_FILL: begin
                if (plot_ready) begin
                    if (r_y != r_y1) begin
                        w_y_nxt = r_y + Y_W'(1);
                    end else if (r_x != r_x1) begin
                        w_y_nxt = r_y0;
                        w_x_nxt = r_x + X_W'(1);
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!start) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_mode       <= '0;
            r_colour_in  <= '0;
            r_x0         <= '0;
            r_x1         <= '0;
            r_y0         <= '0;
            r_y1         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_vga_colour <= '0;
            r_plot       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_plot  <= (w_state_nxt == ST_FILL);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_FILL) begin
                r_vga_colour <= w_colour_nxt;
            end
            // Request parameters are captured once; later input changes are ignored
            if (r_state == ST_IDLE && start) begin
                r_mode      <= mode;
                r_colour_in <= colour_in;
                r_x0        <= x0;
                r_x1        <= x1;
                r_y0        <= y0;
                r_y1        <= y1;
            end
            if (r_state == ST_SETUP) begin
                r_x1 <= w_x1_clip;
                r_y1 <= w_y1_clip;
            end
        end
    end

    assign done       = r_done;
    assign vga_plot   = r_plot;
    assign vga_x      = r_x;
    assign vga_y      = r_y;
    assign vga_colour = r_vga_colour;

endmodule

// File: tb/tb_fill_rect.sv
// Randomized scoreboard bench for fill_rect: a rectangle model queues expected
// pixels, a negedge monitor pops and compares every accepted pixel.
module tb_fill_rect;

    localparam int H_RES = 160;
    localparam int V_RES = 120;
    localparam int CW    = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [2:0] colour_in;
    logic [7:0] x0;
    logic [7:0] x1;
    logic [6:0] y0;
    logic [6:0] y1;
    logic       plot_ready;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    fill_rect dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .colour_in  (colour_in),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .plot_ready (plot_ready),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_tx     = 0;
    int   n_stall  = 0;
    int   pr_mode  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: clip the far corner to the screen, then list pixels column by column
    function automatic int model_fill(input int m, input int c, input int xa, input int xb,
                                      input int ya, input int yb);
        int xe;
        int ye;
        int cnt;
        int mask;
        pix_t p;
        mask = (1 << CW) - 1;
        xe = (xb > H_RES - 1) ? H_RES - 1 : xb;
        ye = (yb > V_RES - 1) ? V_RES - 1 : yb;
        cnt = 0;
        for (int xx = xa; xx <= xe; xx++) begin
            for (int yy = ya; yy <= ye; yy++) begin
                p.x = xx;
                p.y = yy;
                case (m)
                    0:       p.c = c;
                    1:       p.c = xx & mask;
                    2:       p.c = yy & mask;
                    default: p.c = (xx ^ yy) & mask;
                endcase
                exp_q.push_back(p);
                cnt++;
            end
        end
        return cnt;
    endfunction

    // plot_ready driver: 0 = always ready, 1 = toggling, 2 = random
    initial begin
        plot_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (pr_mode)
                0:       plot_ready = 1'b1;
                1:       plot_ready = ~plot_ready;
                default: plot_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare accepted pixels, and hold-stability during stalls
    initial begin
        bit   stall_prev;
        int   sx;
        int   sy;
        int   sc;
        pix_t p;
        stall_prev = 1'b0;
        sx = 0;
        sy = 0;
        sc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (done) check_eq("plot_during_done", int'(vga_plot), 0);
                if (stall_prev && vga_plot) begin
                    check_eq("stall_hold_x", int'(vga_x), sx);
                    check_eq("stall_hold_y", int'(vga_y), sy);
                    check_eq("stall_hold_colour", int'(vga_colour), sc);
                end
                if (vga_plot && plot_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("plot_with_empty_queue", int'(vga_plot), 0);
                    end else begin
                        p = exp_q.pop_front();
                        check_eq("pix_x", int'(vga_x), p.x);
                        check_eq("pix_y", int'(vga_y), p.y);
                        check_eq("pix_colour", int'(vga_colour), p.c);
                    end
                    n_tx++;
                end
                stall_prev = vga_plot && !plot_ready;
                if (stall_prev) begin
                    sx = int'(vga_x);
                    sy = int'(vga_y);
                    sc = int'(vga_colour);
                    n_stall++;
                end
            end
        end
    end

    task automatic run_fill(input int m, input int c, input int xa, input int xb,
                            input int ya, input int yb, input int prm, input int hold);
        int n;
        int stall0;
        int cycles;
        bit got;
        pr_mode = prm;
        n = model_fill(m, c, xa, xb, ya, yb);
        stall0 = n_stall;
        @(posedge clk);
        #1;
        mode      = 2'(m);
        colour_in = 3'(c);
        x0        = 8'(xa);
        x1        = 8'(xb);
        y0        = 7'(ya);
        y1        = 7'(yb);
        start     = 1'b1;
        cycles = 0;
        got = 1'b0;
        while (!got && cycles < 25000) begin
            @(posedge clk);
            cycles++;
            #1;
            if (cycles == 1) begin
                mode      = 2'($urandom);
                colour_in = 3'($urandom);
                x0        = 8'($urandom);
                x1        = 8'($urandom);
                y0        = 7'($urandom);
                y1        = 7'($urandom);
            end
            if (done) got = 1'b1;
        end
        if (!got) begin
            check_eq("done_timeout", int'(done), 1);
        end else begin
            check_eq("done_latency", cycles, n + 2 + (n_stall - stall0));
            check_eq("pixels_outstanding", exp_q.size(), 0);
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
            check_eq("done_held_with_start", int'(done), 1);
            check_eq("no_plot_in_done", int'(vga_plot), 0);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("done_clears_in_idle", int'(done), 0);
        exp_q.delete();
    endtask

    initial begin
        int base;
        int xa;
        int xb;
        int ya;
        int yb;
        int guard;
        rst       = 1'b1;
        start     = 1'b1;
        mode      = 2'd3;
        colour_in = 3'd7;
        x0        = 8'd5;
        x1        = 8'd9;
        y0        = 7'd5;
        y1        = 7'd9;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_plot", int'(vga_plot), 0);
        check_eq("rst_x", int'(vga_x), 0);
        check_eq("rst_y", int'(vga_y), 0);
        check_eq("rst_colour", int'(vga_colour), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_after_rst_plot", int'(vga_plot), 0);

        run_fill(1, 0, 0, 255, 0, 127, 0, 0);
        run_fill(0, 5, 150, 200, 110, 127, 0, 1);
        run_fill(0, 2, 10, 9, 0, 5, 0, 0);
        run_fill(3, 0, 3, 3, 4, 4, 0, 2);
        run_fill(2, 0, 0, 1, 0, 1, 1, 0);

        // Abort a fill after 50 accepted pixels, then confirm a clean restart
        pr_mode = 0;
        void'(model_fill(3, 0, 0, 19, 0, 19));
        base = n_tx;
        @(posedge clk);
        #1;
        mode  = 2'd3;
        x0    = 8'd0;
        x1    = 8'd19;
        y0    = 7'd0;
        y1    = 7'd19;
        start = 1'b1;
        guard = 0;
        while ((n_tx - base) < 50 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("abort_tx_count", n_tx - base, 50);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check_eq("abort_plot", int'(vga_plot), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_x", int'(vga_x), 0);
        check_eq("abort_y", int'(vga_y), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_eq("abort_stays_quiet", int'(vga_plot), 0);
        end
        run_fill(3, 0, 0, 19, 0, 19, 0, 0);

        for (int i = 0; i < 25; i++) begin
            xa = $urandom_range(0, 170);
            xb = xa + $urandom_range(0, 14);
            if (xb > 255) xb = 255;
            ya = $urandom_range(0, 125);
            yb = ya + $urandom_range(0, 12);
            if (yb > 127) yb = 127;
            if ($urandom_range(0, 7) == 0 && xa > 0) xb = xa - 1;
            run_fill($urandom_range(0, 3), $urandom_range(0, 7), xa, xb, ya, yb,
                     $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
